// File: rtl/icache_ctrl.sv
// icache_ctrl: two-way set-associative read-only instruction cache controller.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt counters.
module icache_ctrl #(
  parameter int TAG_W  = 24,
  parameter int LINE_W = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  typedef enum logic [2:0] {
    WAIT,
    LOOKUP,
    MEM_REQ,
    RECV,
    REFILL,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag0  [8];
  logic [TAG_W-1:0]  tag1  [8];
  logic [LINE_W-1:0] line0 [8];
  logic [LINE_W-1:0] line1 [8];
  logic [7:0]        valid0, valid1, lru;

  logic [31:0]       addr_q, rsp_q;
  logic [LINE_W-1:0] lbuf;
  logic [2:0]        beat;

  logic [2:0]        idx, word;
  logic [TAG_W-1:0]  tag;
  logic [7:0]        sel;
  logic              hit0, hit1, hit, victim;
  logic [LINE_W-1:0] hit_line;
  logic              unused;

  assign idx  = addr_q[7:5];
  assign word = addr_q[4:2];
  assign tag  = addr_q[31 -: TAG_W];
  assign sel  = {word, 5'b0};

  assign hit0 = valid0[idx] && (tag0[idx] == tag);
  assign hit1 = valid1[idx] && (tag1[idx] == tag);
  assign hit  = hit0 | hit1;

  // Fill empty ways first, otherwise evict the least recently used.
  assign victim = !valid0[idx] ? 1'b0 :
                  !valid1[idx] ? 1'b1 : lru[idx];

  assign hit_line = hit0 ? line0[idx] : line1[idx];
  assign unused   = ^addr_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    to_cpu_inst_req_ready  = 1'b0;
    to_cpu_cache_rsp_valid = 1'b0;
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_rsp_ready    = 1'b0;
    unique case (state)
      WAIT: begin
        to_cpu_inst_req_ready = 1'b1;
        if (from_cpu_inst_req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = hit ? RESP : MEM_REQ;
      MEM_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) state_nxt = RECV;
      end
      RECV: begin
        to_mem_rd_rsp_ready = 1'b1;
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last)
          state_nxt = REFILL;
      end
      REFILL: state_nxt = RESP;
      RESP: begin
        to_cpu_cache_rsp_valid = 1'b1;
        if (from_cpu_cache_rsp_ready) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  assign to_cpu_cache_rsp_data = rsp_q;
  assign to_mem_rd_req_addr    = {addr_q[31:5], 5'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rsp_q  <= '0;
      lbuf   <= '0;
      beat   <= '0;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
      for (int i = 0; i < 8; i++) begin
        tag0[i]  <= '0;
        tag1[i]  <= '0;
        line0[i] <= '0;
        line1[i] <= '0;
      end
    end else begin
      unique case (state)
        WAIT: begin
          if (from_cpu_inst_req_valid)
            addr_q <= from_cpu_inst_req_addr;
        end
        LOOKUP: begin
          if (hit) begin
            rsp_q    <= hit_line[sel +: 32];
            lru[idx] <= hit0;
          end
        end
        MEM_REQ: beat <= '0;
        RECV: begin
          if (from_mem_rd_rsp_valid) begin
            lbuf[{beat, 5'b0} +: 32] <= from_mem_rd_rsp_data;
            beat <= beat + 3'd1;
          end
        end
        REFILL: begin
          if (victim) begin
            tag1[idx]   <= tag;
            line1[idx]  <= lbuf;
            valid1[idx] <= 1'b1;
          end else begin
            tag0[idx]   <= tag;
            line0[idx]  <= lbuf;
            valid0[idx] <= 1'b1;
          end
          lru[idx] <= ~victim;
          rsp_q    <= lbuf[sel +: 32];
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
